// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit arbiter
// Contents:
//   ST_IDLE / ST_GRANT       : arbiter FSM encoding
//   DEFAULT_TIMEOUT_CYCLES   : default in-packet idle limit before a lock is dropped
//   baud_div()               : clock cycles per UART bit for a given clock and baud rate
package uart_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1250;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter bundle of the UART transmit arbiter
// Signals:
//   req_valid/req_data/req_last : per-requester byte stream (requester i at bits [i*DATA_BITS +: DATA_BITS])
//   req_ready                   : per-requester accept
//   tx_valid/tx_data/tx_ready   : byte stream toward the UART transmitter
//   cts_n                       : synchronized clear-to-send, active-low
//   grant_id/busy/timeout       : arbitration status
// Modports: master = requesters + transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_valid;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_ready;
  logic                         cts_n;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready, cts_n,
    input  req_ready, tx_valid, tx_data, grant_id, busy, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready, cts_n,
    output req_ready, tx_valid, tx_data, grant_id, busy, timeout
  );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin winner select
// Ports:
//   req   : request vector
//   ptr   : last served index; search starts at (ptr+1) mod NUM_REQ
//   idx   : winning index (0 when nothing found)
//   found : at least one request was set
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Walk the ring once, beginning just after the last winner.
    for (int j = 1; j <= NUM_REQ; j++) begin
      if (!found && req[(int'(ptr) + j) % NUM_REQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + j) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART transmitter
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : uart_tx_arbiter_if.slave (requester streams, transmitter stream, cts_n, status)
// A granted requester keeps the transmitter until its req_last byte transfers, or until it
// has been idle for TIMEOUT_CYCLES unstalled cycles, whichever comes first.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [0:0]           state;
  logic [GW-1:0]        grant_id;
  logic [GW-1:0]        rr_ptr;
  logic [CW-1:0]        idle_cnt;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 timeout;

  logic [GW-1:0]        pick_idx;
  logic                 pick_found;

  logic                 g_valid;
  logic                 g_last;
  logic [DATA_BITS-1:0] g_data;
  logic                 tx_open;
  logic                 accept;
  logic                 xfer;
  logic                 stall;
  logic                 idle_tick;
  logic                 cnt_hit;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Mux out the granted requester's stream.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_id) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // The holding register can take a byte when empty or draining this cycle.
  assign tx_open   = !tx_valid || bus.tx_ready;
  assign accept    = !rst && (state == ST_GRANT) && !bus.cts_n && tx_open;
  assign xfer      = accept && g_valid;
  // A stall is the fault of the transmitter side, not the requester, so it must not
  // count toward the requester's idle timeout.
  assign stall     = bus.cts_n || !tx_open;
  assign idle_tick = (state == ST_GRANT) && !g_valid && !stall;
  assign cnt_hit   = idle_tick && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(NUM_REQ - 1);
      idle_cnt <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;

      if (xfer) begin
        tx_valid <= 1'b1;
        tx_data  <= g_data;
      end else if (bus.tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (!bus.cts_n && pick_found) begin
            grant_id <= pick_idx;
            state    <= ST_GRANT;
          end
        end
        default: begin
          if (xfer && g_last) begin
            state    <= ST_IDLE;
            rr_ptr   <= grant_id;
            idle_cnt <= '0;
          end else if (xfer || g_valid) begin
            idle_cnt <= '0;
          end else if (cnt_hit) begin
            state    <= ST_IDLE;
            rr_ptr   <= grant_id;
            idle_cnt <= '0;
            timeout  <= 1'b1;
          end else if (idle_tick) begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = (state == ST_GRANT);
  assign bus.timeout   = timeout;

endmodule
